stream_xbar_arbiter: RTL and testbench
======================================

# stream_xbar_arbiter

Per-output packet arbiter for the stream crossbar switch. For every master (output) port it picks one requesting source stream in round-robin order, locks that grant until the packet's last beat is accepted, and drives the one-hot grant vectors that steer the crossbar datapath. It also returns per-source `ready` to the source streams. It sits beside the combinational switch and shares its clock domain; the grant vectors connect directly to the switch's per-output request inputs.

## Interface
- `S_DATA_COUNT`, 2, number of source (input) streams; ≥ 2
- `M_DATA_COUNT`, 3, number of master (output) streams; ≥ 2
- `T_ID___WIDTH`, localparam `$clog2(S_DATA_COUNT)`, source index width
- `T_DEST_WIDTH`, localparam `$clog2(M_DATA_COUNT)`, destination index width

Ports:
- `clk_i`  in  1  single clock. All state updates on its rising edge.
- `rst_n_i`  in  1  reset. Asynchronous, active-low.
- `s_valid_i`  in  [S_DATA_COUNT-1:0]  source beat valid
- `s_last_i`  in  [S_DATA_COUNT-1:0]  source beat is the last beat of its packet
- `s_dest_i`  in  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  destination output index per source
- `s_ready_o`  out  [S_DATA_COUNT-1:0]  source beat accepted this cycle
- `m_ready_i`  in  [M_DATA_COUNT-1:0]  output-side ready
- `grant_o`  out  [S_DATA_COUNT-1:0] x M_DATA_COUNT  one-hot or zero grant per output. Feeds the switch request inputs.
- `busy_o`  out  [M_DATA_COUNT-1:0]  output port locked to a source

## Operation
- Request: source s requests output m when `s_valid_i[s]` is high, `s_dest_i[s]==m`, and s is not locked on another output.
- `s_dest_i` values ≥ M_DATA_COUNT never request anything. Such a source never sees `s_ready_o` high.
- Each output m runs an independent 2-state FSM: IDLE and BUSY.
  - IDLE: if any source requests m, register the winner. Next state is BUSY, with `grant_o[m]` one-hot on the winner. If there is no request, stay IDLE with `grant_o[m]=0`.
  - BUSY: the grant is held. A beat transfers when `s_valid_i[w] & m_ready_i[m]`. If the transferred beat has `s_last_i[w]`, next state is IDLE and the pointer is updated. Otherwise the FSM stays BUSY.
  - In BUSY, `s_dest_i[w]` and other sources' requests are ignored until release.
- Winner selection: the first requesting source at or after `ptr[m]`, scanning upward and wrapping modulo S_DATA_COUNT.
  - On release, `ptr[m] <= winner+1`, wrapping to 0 after S_DATA_COUNT-1.
- `s_ready_o[s]` = OR over m of (`grant_o[m][s]` & `m_ready_i[m]`). This is combinational from registered grant and the `m_ready_i` input.
- `busy_o[m]` = (state==BUSY).
- Because a source is locked on at most one output, at most one `grant_o[m][s]` is high per source in any cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - all FSMs IDLE
  - `ptr`=0
  - `grant_o`=0, `busy_o`=0, `s_ready_o`=0
- Grant latency: a request sampled in IDLE at edge k gives a grant valid from after edge k until release.
  - Earliest first-beat acceptance is the cycle after the request is first seen.
- Release bubble: after the last beat is accepted at edge k, the output is IDLE during cycle k+1.
  - A new grant is visible after edge k+1, so there is one dead cycle between packets on the same output.
- A one-beat packet (`s_last_i` high on its first beat) occupies BUSY for exactly one cycle if `m_ready_i` is high.
- Simultaneous requests from several sources to the same IDLE output: exactly one is granted, chosen by `ptr`. The losers keep requesting.
- Different outputs may grant and release in the same cycle, independently.
- Dropping `s_valid_i` while BUSY: the grant is held and no beat transfers. No timeout.
- Reset mid-packet: the grant is dropped immediately and asynchronously. Arbitration restarts from `ptr`=0.

## Structure
- Shared package `stream_xbar_pkg`:
  - index-width helper function used for `T_ID___WIDTH`/`T_DEST_WIDTH`
  - FSM state enum `arb_state_t {ARB_IDLE, ARB_BUSY}`
- Sub-module `stream_rr_arbiter`:
  - one instance per output, generated M_DATA_COUNT times
  - contains the FSM, the pointer and the winner scan
  - inputs: request vector, valid/last of the winner, ready
  - outputs: one-hot grant and busy
- The top level computes the request vectors (dest decode plus lock exclusion) and the `s_ready_o` OR-reduction.

## Test plan
- Reset: hold `rst_n_i`=0 with all `s_valid_i`=1 → `grant_o`, `busy_o`, `s_ready_o` all 0. Release reset → a grant appears one cycle later.
- Single packet: source 1 sends 3 beats to output 2 with `m_ready_i`=all 1 → `grant_o[2]`=2'b10 for 3 cycles, `s_ready_o[1]` high 3 cycles, then `busy_o[2]`=0 for 1 cycle.
- Contention: sources 0 and 1 both target output 0 continuously with 2-beat packets → grants alternate 01,10,01…, each separated by one idle cycle.
- Backpressure: `m_ready_i[0]`=0 for 4 cycles mid-packet → the grant is held, `s_ready_o`=0, and the packet completes with no dropped or extra beats.
- Parallel outputs: source 0→output 0 and source 1→output 1 simultaneously → both granted in the same cycle, no interference.
- Invalid dest: `s_dest_i[0]`=3 with M=3 → no grant and `s_ready_o[0]`=0 indefinitely. Reset asserted mid-packet on another source → the grant clears immediately.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar arbiter.
package stream_xbar_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter for one output: grants a single requester and
// holds that grant until the winner's last beat is accepted.
module stream_rr_arbiter
    import stream_xbar_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req_i,
    input  logic         win_valid_i,
    input  logic         win_last_i,
    input  logic         ready_i,
    output logic [N-1:0] grant_o,
    output logic         busy_o
);

    arb_state_t       state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [IDX_W-1:0] win_r, win_s;
    logic [N-1:0]     grant_r, grant_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             found_s;

    // State, pointer, winner and grant registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ARB_IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            grant_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            grant_r <= grant_s;
        end
    end

    // First requester at or after the pointer, wrapping modulo N
    always_comb begin
        found_s    = 1'b0;
        pick_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req_i[(int'(ptr_r) + i) % N]) begin
                found_s    = 1'b1;
                pick_idx_s = IDX_W'((int'(ptr_r) + i) % N);
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Next-state logic: lock on a winner, release after its last beat
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        grant_s = grant_r;
        case (state_r)
            ARB_IDLE: begin
                if (found_s) begin
                    state_s = ARB_BUSY;
                    win_s   = pick_idx_s;
                    grant_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
                end else begin
                    grant_s = '0;
                end
            end
            ARB_BUSY: begin
                if (win_valid_i && ready_i && win_last_i) begin
                    state_s = ARB_IDLE;
                    grant_s = '0;
                    ptr_s   = (win_r == IDX_W'(N - 1)) ? '0 : win_r + IDX_W'(1);
                end else begin
                    state_s = ARB_BUSY;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // Outputs straight from registered state
    always_comb begin
        grant_o = grant_r;
        busy_o  = (state_r == ARB_BUSY);
    end

endmodule

// File: rtl/stream_xbar_arbiter.sv
// Per-output packet arbiter for the stream crossbar: request decode with lock
// exclusion, one round-robin arbiter per output, and source ready return.
module stream_xbar_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = idx_width(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = idx_width(M_DATA_COUNT)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                    s_last_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
    output logic [S_DATA_COUNT-1:0]                    s_ready_o,
    input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
    output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]  grant_o,
    output logic [M_DATA_COUNT-1:0]                    busy_o
);

    logic [S_DATA_COUNT-1:0]                   locked_s;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_s;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_s;
    logic [M_DATA_COUNT-1:0]                   win_valid_s;
    logic [M_DATA_COUNT-1:0]                   win_last_s;

    // Per-source lock flag and ready return from the registered grants
    always_comb begin
        locked_s  = '0;
        s_ready_o = '0;
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                locked_s[s]  = locked_s[s] | grant_s[m][s];
                s_ready_o[s] = s_ready_o[s] | (grant_s[m][s] & m_ready_i[m]);
            end
        end
    end

    // Destination decode; out-of-range destinations match no output
    always_comb begin
        req_s       = '0;
        win_valid_s = '0;
        win_last_s  = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                req_s[m][s] = s_valid_i[s] & ~locked_s[s] &
                              (s_dest_i[s] == T_DEST_WIDTH'(m));
            end
            win_valid_s[m] = |(grant_s[m] & s_valid_i);
            win_last_s[m]  = |(grant_s[m] & s_last_i);
        end
    end

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
        stream_rr_arbiter #(
            .N     (S_DATA_COUNT),
            .IDX_W (T_ID___WIDTH)
        ) u_arb (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .req_i       (req_s[m]),
            .win_valid_i (win_valid_s[m]),
            .win_last_i  (win_last_s[m]),
            .ready_i     (m_ready_i[m]),
            .grant_o     (grant_s[m]),
            .busy_o      (busy_o[m])
        );
    end

    assign grant_o = grant_s;

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// Randomised scoreboard bench for stream_xbar_arbiter with a packet-level
// reference model (owner/pointer per output).
module tb_stream_xbar_arbiter;

    localparam int S  = 2;
    localparam int M  = 3;
    localparam int DW = $clog2(M);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [S-1:0]           s_valid, s_last, s_ready;
    logic [S-1:0][DW-1:0]   s_dest;
    logic [M-1:0]           m_ready, busy;
    logic [M-1:0][S-1:0]    grant;

    typedef struct packed {
        logic [M-1:0][S-1:0] grant;
        logic [M-1:0]        busy;
        logic [S-1:0]        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    int   owner[M];
    int   ptr[M];
    bit   pkt_active[S];
    int   pkt_dest[S];
    int   pkt_left[S];
    int   valid_pct  = 100;
    bit   refill     = 1'b0;
    int   fixed_dest = -1;
    int   fixed_len  = 2;

    always #5 clk = ~clk;

    stream_xbar_arbiter #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_dest_i  (s_dest),
        .s_ready_o (s_ready),
        .m_ready_i (m_ready),
        .grant_o   (grant),
        .busy_o    (busy)
    );

    // Monitor: compare each cycle's outputs against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (grant !== mon_e.grant) begin
                failures++;
                $display("FAIL grant t=%0t actual=%b required=%b", $time, grant, mon_e.grant);
            end
            checks++;
            if (busy !== mon_e.busy) begin
                failures++;
                $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, mon_e.busy);
            end
            checks++;
            if (s_ready !== mon_e.ready) begin
                failures++;
                $display("FAIL s_ready t=%0t actual=%b required=%b", $time, s_ready, mon_e.ready);
            end
        end
    end

    task automatic start_pkt(input int s, input int d, input int len);
        pkt_active[s] = 1'b1;
        pkt_dest[s]   = d;
        pkt_left[s]   = len;
    endtask

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            owner[m] = -1;
            ptr[m]   = 0;
        end
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model
    task automatic step(input bit rst, input logic [M-1:0] mready);
        logic [S-1:0] v, l;
        exp_t         e;
        bit           locked[S];
        int           cand;
        @(posedge clk);
        #1;
        for (int s = 0; s < S; s++) begin
            v[s]      = pkt_active[s] && ($urandom_range(99, 0) < valid_pct);
            l[s]      = (pkt_left[s] == 1);
            s_dest[s] = DW'(pkt_dest[s]);
        end
        s_valid = v;
        s_last  = l;
        m_ready = mready;
        rst_n   = rst;
        if (!rst) model_reset();

        e = '0;
        for (int m = 0; m < M; m++) begin
            e.busy[m] = (owner[m] >= 0);
            for (int s = 0; s < S; s++) begin
                e.grant[m][s] = (owner[m] == s);
                e.ready[s]    = e.ready[s] | ((owner[m] == s) && mready[m]);
            end
        end
        exp_q.push_back(e);

        if (rst) begin
            for (int s = 0; s < S; s++) begin
                locked[s] = 1'b0;
                for (int m = 0; m < M; m++) if (owner[m] == s) locked[s] = 1'b1;
            end
            for (int m = 0; m < M; m++) begin
                if (owner[m] < 0) begin
                    for (int k = 0; k < S; k++) begin
                        cand = (ptr[m] + k) % S;
                        if (owner[m] < 0 && v[cand] && !locked[cand] && pkt_dest[cand] == m)
                            owner[m] = cand;
                    end
                end else if (v[owner[m]] && mready[m] && l[owner[m]]) begin
                    ptr[m]   = (owner[m] + 1) % S;
                    owner[m] = -1;
                end
            end
        end

        for (int s = 0; s < S; s++) begin
            if (v[s] && e.ready[s]) begin
                pkt_left[s]--;
                if (pkt_left[s] == 0) pkt_active[s] = 1'b0;
            end
            if (refill && !pkt_active[s] && (fixed_dest >= 0 || $urandom_range(2, 0) == 0)) begin
                if (fixed_dest >= 0) start_pkt(s, fixed_dest, fixed_len);
                else start_pkt(s, int'($urandom_range(M - 1, 0)), int'($urandom_range(4, 1)));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_dest  = '0;
        m_ready = '0;
        model_reset();
        for (int s = 0; s < S; s++) begin
            pkt_active[s] = 1'b0;
            pkt_dest[s]   = 0;
            pkt_left[s]   = 0;
        end

        // reset held with every source valid, then release
        start_pkt(0, 0, 2);
        start_pkt(1, 1, 2);
        repeat (3) step(1'b0, '1);
        repeat (6) step(1'b1, '1);

        // single 3-beat packet, source 1 -> output 2
        start_pkt(1, 2, 3);
        repeat (6) step(1'b1, '1);

        // backpressure on output 0 mid-packet
        start_pkt(0, 0, 4);
        repeat (2) step(1'b1, 3'b111);
        repeat (4) step(1'b1, 3'b110);
        repeat (5) step(1'b1, 3'b111);

        // parallel outputs
        start_pkt(0, 0, 3);
        start_pkt(1, 1, 3);
        repeat (6) step(1'b1, '1);

        // contention: both sources stream 2-beat packets to output 0
        refill     = 1'b1;
        fixed_dest = 0;
        fixed_len  = 2;
        start_pkt(0, 0, 2);
        start_pkt(1, 0, 2);
        repeat (16) step(1'b1, '1);
        refill = 1'b0;
        repeat (8) step(1'b1, '1);

        // invalid destination, then reset mid-packet on the other source
        start_pkt(0, 3, 2);
        start_pkt(1, 1, 6);
        repeat (4) step(1'b1, '1);
        step(1'b0, '1);
        repeat (10) step(1'b1, '1);
        pkt_active[0] = 1'b0;
        pkt_left[0]   = 0;
        repeat (4) step(1'b1, '1);

        // randomised traffic with valid gaps, backpressure and rare resets
        refill     = 1'b1;
        fixed_dest = -1;
        valid_pct  = 80;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(299, 0) != 0), M'($urandom));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
